// File: rtl/mdio_responder.sv
// Clause-22 MDIO responder (PHY-side management slave).
//
// Oversamples MDC/MDIO in the clk_clk domain and decodes read and write frames addressed to
// PHY_ADDR. Register map:
//   reg 0    : read/write, reset value REG0_RST, exported on reg0_q
//   reg 1    : read-only, returns status_in live
//   reg 2/3  : read-only, PHY_ID1 / PHY_ID2
//   reg 4-7  : read/write scratch storage
//   reg 8-31 : read as zero
// Every accepted write frame pulses reg_wr_valid for one cycle, including writes to read-only
// addresses, which leave storage unchanged.
//
// Ports:
//   clk_clk, reset_reset        system clock, asynchronous active-high reset
//   mdio_mdc, mdio_mdio_in      MDIO management clock and sampled line (asynchronous)
//   mdio_mdio_out, mdio_mdio_oen  line drive data and active-low drive enable
//   status_in                   live value of register 1
//   reg0_q                      current register 0
//   reg_wr_valid/addr/data      write-frame strobe with its address and data
//
// Build option: define MDIO_RESP_PREAMBLE_CHECK_EN to require a full 32-bit preamble before each
// start; otherwise a single preamble 1 is enough (preamble suppression).
module mdio_responder #(
  parameter logic [4:0]  PHY_ADDR = 5'd1,
  parameter logic [15:0] PHY_ID1  = 16'h0000,
  parameter logic [15:0] PHY_ID2  = 16'h0000,
  parameter logic [15:0] REG0_RST = 16'h1140
) (
  input  logic        clk_clk,
  input  logic        reset_reset,
  input  logic        mdio_mdc,
  input  logic        mdio_mdio_in,
  output logic        mdio_mdio_out,
  output logic        mdio_mdio_oen,
  input  logic [15:0] status_in,
  output logic [15:0] reg0_q,
  output logic        reg_wr_valid,
  output logic [4:0]  reg_wr_addr,
  output logic [15:0] reg_wr_data
);

  typedef enum logic [2:0] {
    StIdle, StSt, StOp, StPhyad, StRegad, StTa, StData, StSkip
  } state_t;

  state_t      state;
  logic        mdc_s1, mdc_s2, mdc_s3;
  logic        mdio_s1, mdio_s2;
  logic [5:0]  pre_cnt;
  logic [4:0]  bit_cnt;
  logic [1:0]  op_q;
  logic        is_read;
  logic [4:0]  phyad_q;
  logic [4:0]  regad_q;
  logic [15:0] shreg;
  logic [15:0] regs_q [4];

  logic        mdc_rise;
  logic        sample;
  logic [15:0] rd_value;
  logic [15:0] wr_word;

  // mdc_s3 only serves edge detection; both lines see the same two-flop latency.
  assign mdc_rise = mdc_s2 & ~mdc_s3;
  assign sample   = mdio_s2;
  assign wr_word  = {shreg[14:0], sample};

  always_comb begin
    rd_value = 16'h0000;
    case (regad_q)
      5'd0:                     rd_value = reg0_q;
      5'd1:                     rd_value = status_in;
      5'd2:                     rd_value = PHY_ID1;
      5'd3:                     rd_value = PHY_ID2;
      5'd4, 5'd5, 5'd6, 5'd7:   rd_value = regs_q[regad_q[1:0]];
      default:                  rd_value = 16'h0000;
    endcase
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state         <= StIdle;
      mdc_s1        <= 1'b0;
      mdc_s2        <= 1'b0;
      mdc_s3        <= 1'b0;
      mdio_s1       <= 1'b0;
      mdio_s2       <= 1'b0;
      pre_cnt       <= 6'd0;
      bit_cnt       <= 5'd0;
      op_q          <= 2'b00;
      is_read       <= 1'b0;
      phyad_q       <= 5'd0;
      regad_q       <= 5'd0;
      shreg         <= 16'h0000;
      mdio_mdio_out <= 1'b1;
      mdio_mdio_oen <= 1'b1;
      reg0_q        <= REG0_RST;
      for (int i = 0; i < 4; i++) regs_q[i] <= 16'h0000;
      reg_wr_valid  <= 1'b0;
      reg_wr_addr   <= 5'd0;
      reg_wr_data   <= 16'h0000;
    end else begin
      mdc_s1       <= mdio_mdc;
      mdc_s2       <= mdc_s1;
      mdc_s3       <= mdc_s2;
      mdio_s1      <= mdio_mdio_in;
      mdio_s2      <= mdio_s1;
      reg_wr_valid <= 1'b0;

      if (mdc_rise) begin
        case (state)
          StIdle: begin
            if (sample) begin
              if (pre_cnt != 6'd32) pre_cnt <= pre_cnt + 6'd1;
            end else begin
`ifdef MDIO_RESP_PREAMBLE_CHECK_EN
              // A short preamble is discarded entirely.
              if (pre_cnt == 6'd32) state <= StSt;
              pre_cnt <= 6'd0;
`else
              if (pre_cnt != 6'd0) begin
                state   <= StSt;
                pre_cnt <= 6'd0;
              end
`endif
            end
          end

          // First start bit (0) was consumed in idle; this is the second one.
          StSt: begin
            bit_cnt <= 5'd0;
            state   <= sample ? StOp : StSkip;
          end

          StOp: begin
            op_q <= {op_q[0], sample};
            if (bit_cnt == 5'd1) begin
              bit_cnt <= 5'd0;
              case ({op_q[0], sample})
                2'b10: begin
                  is_read <= 1'b1;
                  state   <= StPhyad;
                end
                2'b01: begin
                  is_read <= 1'b0;
                  state   <= StPhyad;
                end
                default: state <= StSkip;
              endcase
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end

          StPhyad: begin
            phyad_q <= {phyad_q[3:0], sample};
            if (bit_cnt == 5'd4) begin
              bit_cnt <= 5'd0;
              state   <= StRegad;
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end

          StRegad: begin
            regad_q <= {regad_q[3:0], sample};
            if (bit_cnt == 5'd4) begin
              bit_cnt <= 5'd0;
              state   <= (phyad_q == PHY_ADDR) ? StTa : StSkip;
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end

          StTa: begin
            if (bit_cnt == 5'd0) begin
              // Reads ignore the first TA bit (master releases the line).
              if (!is_read && !sample) state <= StSkip;
              else bit_cnt <= 5'd1;
            end else begin
              bit_cnt <= 5'd0;
              if (is_read) begin
                mdio_mdio_oen <= 1'b0;
                mdio_mdio_out <= 1'b0;
                shreg         <= rd_value;
                state         <= StData;
              end else if (sample) begin
                state <= StSkip;
              end else begin
                state <= StData;
              end
            end
          end

          StData: begin
            if (is_read) begin
              if (bit_cnt == 5'd16) begin
                mdio_mdio_oen <= 1'b1;
                mdio_mdio_out <= 1'b1;
                bit_cnt       <= 5'd0;
                state         <= StIdle;
              end else begin
                mdio_mdio_out <= shreg[15];
                shreg         <= {shreg[14:0], 1'b0};
                bit_cnt       <= bit_cnt + 5'd1;
              end
            end else begin
              shreg <= wr_word;
              if (bit_cnt == 5'd15) begin
                reg_wr_valid <= 1'b1;
                reg_wr_addr  <= regad_q;
                reg_wr_data  <= wr_word;
                if (regad_q == 5'd0) reg0_q <= wr_word;
                else if (regad_q[4:2] == 3'b001) regs_q[regad_q[1:0]] <= wr_word;
                bit_cnt <= 5'd0;
                state   <= StIdle;
              end else begin
                bit_cnt <= bit_cnt + 5'd1;
              end
            end
          end

          StSkip: begin
            mdio_mdio_oen <= 1'b1;
            pre_cnt       <= 6'd0;
            if (sample) state <= StIdle;
          end

          default: state <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mdio_responder.sv
module tb_mdio_responder;

  typedef struct {
    int          n;
    logic [16:0] val;
  } rd_exp_t;

  logic        clk_clk = 1'b0;
  logic        reset_reset = 1'b1;
  logic        mdio_mdc = 1'b0;
  logic        master_drv = 1'b1;
  logic        mdio_line;
  logic        mdio_mdio_out;
  logic        mdio_mdio_oen;
  logic [15:0] status_in = 16'h796D;
  logic [15:0] reg0_q;
  logic        reg_wr_valid;
  logic [4:0]  reg_wr_addr;
  logic [15:0] reg_wr_data;

  int tests = 0;
  int fails = 0;
  logic [20:0] wr_q[$];
  rd_exp_t     rd_q[$];

  // Open-drain style line: the DUT wins while it drives, otherwise the master (pull-up = 1).
  assign mdio_line = mdio_mdio_oen ? master_drv : mdio_mdio_out;

  always #5 clk_clk = ~clk_clk;

  mdio_responder #(
    .PHY_ADDR (5'd1),
    .PHY_ID1  (16'h0141),
    .PHY_ID2  (16'h2BCD),
    .REG0_RST (16'h1140)
  ) dut (
    .clk_clk       (clk_clk),
    .reset_reset   (reset_reset),
    .mdio_mdc      (mdio_mdc),
    .mdio_mdio_in  (mdio_line),
    .mdio_mdio_out (mdio_mdio_out),
    .mdio_mdio_oen (mdio_mdio_oen),
    .status_in     (status_in),
    .reg0_q        (reg0_q),
    .reg_wr_valid  (reg_wr_valid),
    .reg_wr_addr   (reg_wr_addr),
    .reg_wr_data   (reg_wr_data)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic mbit(input logic b);
    master_drv = b;
    #80 mdio_mdc = 1'b1;
    #80 mdio_mdc = 1'b0;
  endtask

  task automatic frame(input logic rd, input logic [4:0] phy, input logic [4:0] ra,
                       input logic [15:0] wd, input int pre, input logic [1:0] ta,
                       input int tail);
    repeat (pre) mbit(1'b1);
    mbit(1'b0);
    mbit(1'b1);
    if (rd) begin
      mbit(1'b1);
      mbit(1'b0);
    end else begin
      mbit(1'b0);
      mbit(1'b1);
    end
    for (int i = 4; i >= 0; i--) mbit(phy[i]);
    for (int i = 4; i >= 0; i--) mbit(ra[i]);
    if (rd) begin
      repeat (tail) mbit(1'b1);
    end else begin
      mbit(ta[1]);
      mbit(ta[0]);
      for (int i = 15; i >= 0; i--) mbit(wd[i]);
    end
    master_drv = 1'b1;
    #200;
  endtask

  task automatic do_write(input logic [4:0] ra, input logic [15:0] wd);
    wr_q.push_back({ra, wd});
    frame(1'b0, 5'd1, ra, wd, 32, 2'b10, 0);
  endtask

  task automatic do_read(input logic [4:0] ra, input logic [15:0] exp, input int pre);
    rd_exp_t e;
    e.n   = 17;
    e.val = {1'b0, exp};
    rd_q.push_back(e);
    frame(1'b1, 5'd1, ra, 16'h0000, pre, 2'b00, 19);
  endtask

  // Write monitor: every strobe must match the next expected write and last one cycle.
  initial begin
    logic        prev;
    logic [20:0] e;
    prev = 1'b0;
    forever begin
      @(negedge clk_clk);
      if (reg_wr_valid) begin
        tests++;
        if (prev) begin
          fails++;
          $display("FAIL wr_pulse_width: strobe high for more than one cycle");
        end else if (wr_q.size() == 0) begin
          fails++;
          $display("FAIL wr_unexpected: got addr %0h data %0h, expected no write",
                   reg_wr_addr, reg_wr_data);
        end else begin
          e = wr_q.pop_front();
          if ({reg_wr_addr, reg_wr_data} !== e) begin
            fails++;
            $display("FAIL wr_strobe: got addr %0h data %0h, expected addr %0h data %0h",
                     reg_wr_addr, reg_wr_data, e[20:16], e[15:0]);
          end
        end
      end
      prev = reg_wr_valid;
    end
  end

  // Read monitor: captures the line at each MDC rise while the DUT drives it.
  initial begin
    rd_exp_t     e;
    logic [16:0] cap;
    int          n;
    forever begin
      @(negedge mdio_mdio_oen);
      cap = '0;
      n   = 0;
      while (mdio_mdio_oen == 1'b0) begin
        @(posedge mdio_mdc or posedge mdio_mdio_oen);
        if (!mdio_mdio_oen) begin
          cap = {cap[15:0], mdio_mdio_out};
          n++;
        end
      end
      tests++;
      if (rd_q.size() == 0) begin
        fails++;
        $display("FAIL rd_unexpected: DUT drove %0d bits value %0h, expected no drive", n, cap);
      end else begin
        e = rd_q.pop_front();
        if (n != e.n || cap !== e.val) begin
          fails++;
          $display("FAIL rd_data: got %0d bits value %0h, expected %0d bits value %0h",
                   n, cap, e.n, e.val);
        end
      end
    end
  end

  initial begin
    rd_exp_t e;
    repeat (3) @(posedge clk_clk);
    #1;
    chk("rst_reg0", 32'(reg0_q), 32'h1140);
    chk("rst_oen", 32'(mdio_mdio_oen), 32'd1);
    chk("rst_out", 32'(mdio_mdio_out), 32'd1);
    chk("rst_valid", 32'(reg_wr_valid), 32'd0);
    chk("rst_addr", 32'(reg_wr_addr), 32'd0);
    chk("rst_data", 32'(reg_wr_data), 32'd0);
    reset_reset = 1'b0;
    repeat (4) @(posedge clk_clk);

    // Write reg 4, read it back; ID, status and unmapped reads.
    do_write(5'd4, 16'hA5C3);
    do_read(5'd4, 16'hA5C3, 32);
    do_read(5'd2, 16'h0141, 32);
    do_read(5'd1, 16'h796D, 32);
    do_read(5'd3, 16'h2BCD, 32);
    do_read(5'd9, 16'h0000, 32);

    // Frames for another PHY: no drive, no strobe.
    frame(1'b1, 5'd2, 5'd2, 16'h0000, 32, 2'b00, 19);
    frame(1'b0, 5'd2, 5'd4, 16'hFFFF, 32, 2'b10, 0);
    do_read(5'd4, 16'hA5C3, 32);

    // Bad write turnaround is dropped; next frame is accepted.
    frame(1'b0, 5'd1, 5'd5, 16'hFFFF, 32, 2'b11, 0);
    do_read(5'd5, 16'h0000, 32);
    do_write(5'd5, 16'h1234);
    do_read(5'd5, 16'h1234, 32);

    // Writes to read-only ID register strobe but do not store.
    do_write(5'd2, 16'hBEEF);
    do_read(5'd2, 16'h0141, 32);

    do_write(5'd0, 16'h3300);
    chk("reg0_write", 32'(reg0_q), 32'h3300);

`ifdef MDIO_RESP_PREAMBLE_CHECK_EN
    frame(1'b1, 5'd1, 5'd2, 16'h0000, 31, 2'b00, 19);
    do_read(5'd3, 16'h2BCD, 32);
`else
    do_read(5'd2, 16'h0141, 1);
`endif

    // Reset in the middle of a read of reg 0 (0x3300): drive window aborts after bit 8.
    e.n   = 8;
    e.val = 17'h00019;
    rd_q.push_back(e);
    frame(1'b1, 5'd1, 5'd0, 16'h0000, 32, 2'b00, 10);
    chk("abort_oen_before", 32'(mdio_mdio_oen), 32'd0);
    chk("abort_bit8", 32'(mdio_mdio_out), 32'd1);
    reset_reset = 1'b1;
    #1;
    chk("abort_oen_async", 32'(mdio_mdio_oen), 32'd1);
    repeat (3) @(posedge clk_clk);
    reset_reset = 1'b0;
    #1;
    chk("abort_reg0", 32'(reg0_q), 32'h1140);
    chk("abort_valid", 32'(reg_wr_valid), 32'd0);

    #1000;
    chk("wr_queue_empty", 32'(wr_q.size()), 32'd0);
    chk("rd_queue_empty", 32'(rd_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mdio_responder.md
MDIO_RESPONDER -- requirements
Module: mdio_responder

Interface
REQ-001 The block SHALL have a parameter PHY_ADDR, default 5'd1: the Clause-22 PHY address this block answers to.
REQ-002 The block SHALL have a parameter PHY_ID1, default 16'h0000: read-only value of register 2.
REQ-003 The block SHALL have a parameter PHY_ID2, default 16'h0000: read-only value of register 3.
REQ-004 The block SHALL have a parameter REG0_RST, default 16'h1140: reset value of register 0.
REQ-005 The block SHALL have the port clk_clk, input, 1 bit: the single system clock; all logic is in this domain.
REQ-006 The block SHALL have the port reset_reset, input, 1 bit: reset, asynchronous and active-high.
REQ-007 The block SHALL have the port mdio_mdc, input, 1 bit: management clock from the MDIO master; asynchronous to clk_clk.
REQ-008 The block SHALL have the port mdio_mdio_in, input, 1 bit: sampled MDIO line.
REQ-009 The block SHALL have the port mdio_mdio_out, output, 1 bit: data driven onto MDIO.
REQ-010 The block SHALL have the port mdio_mdio_oen, output, 1 bit: active-low output enable; 0 means the block drives the line.
REQ-011 The block SHALL have the port status_in, input, 16 bits: live value of register 1.
REQ-012 The block SHALL have the port reg0_q, output, 16 bits: current value of register 0.
REQ-013 The block SHALL have the port reg_wr_valid, output, 1 bit: one-cycle strobe for each accepted write frame.
REQ-014 The block SHALL have the port reg_wr_addr, output, 5 bits: register address of the accepted write.
REQ-015 The block SHALL have the port reg_wr_data, output, 16 bits: data of the accepted write.

Function
REQ-016 mdio_mdc and mdio_mdio_in SHALL each pass through a 2-flop synchronizer; an MDC rising edge is detected on synchronized 0->1; clk_clk is at least 8x MDC.
REQ-017 All MDIO sampling and all output updates SHALL occur only in the clk_clk cycle in which an MDC rising edge is detected ("edge").
REQ-018 The state machine SHALL be IDLE -> ST -> OP -> PHYAD -> REGAD -> TA -> DATA -> IDLE, plus SKIP.
REQ-019 IDLE: each edge sampling 1 SHALL increment a preamble counter, saturating at 32; a sample of 0 with preamble qualified SHALL move to ST.
REQ-020 ST SHALL require a sample of 1; any other ST value (not 01) SHALL go to SKIP.
REQ-021 OP SHALL shift in 2 bits: 10 is a read, 01 is a write; 00 or 11 SHALL go to SKIP.
REQ-022 PHYAD and REGAD SHALL each shift in 5 bits MSB-first; PHYAD != PHY_ADDR SHALL go to SKIP after REGAD without driving the line.
REQ-023 Read: at the edge sampling TA bit 1, the block SHALL set oen=0, out=0; each of the next 16 edges SHALL drive data bits 15..0 in turn; the following edge SHALL set oen=1 and return to IDLE.
REQ-024 Read data SHALL be captured at the TA bit 1 edge: reg 0 = reg0_q; reg 1 = status_in; reg 2 = PHY_ID1; reg 3 = PHY_ID2; regs 4-7 = stored values; regs 8-31 = 16'h0000.
REQ-025 Write: TA bits SHALL be sampled as 1,0, otherwise the frame goes to SKIP with no write; then 16 data bits are sampled MSB-first.
REQ-026 At the 16th write data edge, the block SHALL pulse reg_wr_valid high for exactly one clk_clk cycle with reg_wr_addr and reg_wr_data, and update reg 0 or regs 4-7 in the same cycle.
REQ-027 Writes to regs 1-3 and 8-31 SHALL strobe reg_wr_valid but SHALL leave storage unchanged.
REQ-028 SKIP SHALL keep oen=1, clear the preamble counter, and return to IDLE at the first edge sampling 1.
REQ-029 The preamble counter SHALL be cleared on every entry to ST.
REQ-030 mdio_mdio_oen SHALL be 1 in every state and cycle other than the read drive window of REQ-023.

Reset
REQ-031 Reset SHALL drive: state IDLE, preamble counter 0, mdio_mdio_oen=1, mdio_mdio_out=1, reg_wr_valid=0, reg_wr_addr=0, reg_wr_data=0, reg0_q=REG0_RST, regs 4-7 = 16'h0000, synchronizers = 0.
REQ-032 Reset asserted mid-frame SHALL release the bus immediately (asynchronously) and SHALL perform no write.

Configuration
REQ-033 With MDIO_RESP_PREAMBLE_CHECK_EN defined, IDLE SHALL accept a start only with the counter at 32, and any 0 seen with the count below 32 SHALL clear the counter.
REQ-034 Without MDIO_RESP_PREAMBLE_CHECK_EN, IDLE SHALL accept a start after at least 1 sampled 1 (preamble suppression).

Verification
REQ-035 Preamble 32x1, write PHYAD=1, REGAD=4, data 16'hA5C3 -> exactly one reg_wr_valid with addr 4, data A5C3; subsequent read of reg 4 returns A5C3.
REQ-036 Read REGAD=2 with PHY_ID1=16'h0141 -> oen=0 from the TA bit 1 edge for 17 edges, bits 0,0000_0001_0100_0001, then oen=1.
REQ-037 Frame with PHYAD=2 -> oen stays 1 throughout and no reg_wr_valid.
REQ-038 Write with TA sampled as 1,1 -> no strobe, reg unchanged; next valid frame is accepted.
REQ-039 Macro defined, preamble of 31 ones then ST -> frame ignored; macro undefined, 1 one then ST -> frame accepted.
REQ-040 Reset asserted at read data bit 8 -> oen=1 the same cycle; after release, reg0_q=16'h1140.
